axi4_stream_gen_ctrl: RTL and testbench

AXI4_STREAM_GEN_CTRL -- requirements
Module: axi4_stream_gen_ctrl

---
 rtl/axi4_stream_gen_ctrl_if.sv | 10 +
 rtl/axi4_stream_gen_ctrl.sv | 120 ++++++++++++
 tb/tb_axi4_stream_gen_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_gen_ctrl_if.sv
// AXI4-Stream handshake bundle between the packet-generator controller and its
// downstream sink.
interface axi4_stream_gen_ctrl_if;
  logic TVALID;
  logic TREADY;
  logic TLAST;

  modport master (output TVALID, output TLAST, input TREADY);
  modport slave  (input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/axi4_stream_gen_ctrl.sv
// Packet-framing controller for an AXI4-Stream traffic generator: sequences
// beats, packets and idle gaps, and enables the data counter once per accepted beat.
module axi4_stream_gen_ctrl #(
  parameter int LEN_W = 16,
  parameter int GAP_W = 8
) (
  input  logic                    ACLK,
  input  logic                    RST,
  input  logic                    START,
  input  logic                    STOP,
  input  logic [LEN_W-1:0]        PKT_LEN,
  input  logic [LEN_W-1:0]        NUM_PKTS,
  input  logic [GAP_W-1:0]        GAP,
  axi4_stream_gen_ctrl_if.master  axis,
  output logic                    GEN_EN,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [LEN_W-1:0]        PKT_CNT
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, num_q, beat_q, pkt_q;
  logic [GAP_W-1:0] gap_q, gap_cnt_q;
  logic             stop_pend_q, done_q, done_d;

  logic start_ok, hs, last, final_pkt, end_run;

  assign start_ok  = START && (PKT_LEN != '0);
  assign hs        = axis.TVALID && axis.TREADY;
  assign last      = (state_q == S_SEND) && (beat_q == len_q - LEN_ONE);
  assign final_pkt = (num_q != '0) && (pkt_q + LEN_ONE == num_q);
  // A STOP arriving on the last-beat handshake ends the run at this boundary.
  assign end_run   = final_pkt || stop_pend_q || STOP;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start_ok) state_d = S_SEND;
      S_SEND: begin
        if (hs && last) begin
          if (end_run) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (gap_q != '0) begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (STOP) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt_q == GAP_ONE) begin
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      len_q       <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      beat_q      <= '0;
      pkt_q       <= '0;
      gap_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update sampling pre-edge values.
      state_q <= state_d;
      done_q  <= done_d;
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            len_q  <= PKT_LEN;
            num_q  <= NUM_PKTS;
            gap_q  <= GAP;
            beat_q <= '0;
            pkt_q  <= '0;
          end
        end
        S_SEND: begin
          if (STOP) stop_pend_q <= 1'b1;
          if (hs) begin
            if (last) begin
              beat_q    <= '0;
              pkt_q     <= pkt_q + LEN_ONE;
              gap_cnt_q <= gap_q;
            end else begin
              beat_q <= beat_q + LEN_ONE;
            end
          end
        end
        S_GAP: if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - GAP_ONE;
        default: ;
      endcase
      // Later assignment wins: a run never re-enters IDLE with a stale stop request.
      if (state_d == S_IDLE) stop_pend_q <= 1'b0;
    end
  end

  assign axis.TVALID = (state_q == S_SEND);
  assign axis.TLAST  = last;
  assign GEN_EN      = hs;
  assign BUSY        = (state_q != S_IDLE);
  assign DONE        = done_q;
  assign PKT_CNT     = pkt_q;

endmodule

// File: tb/tb_axi4_stream_gen_ctrl.sv
// Scoreboard bench for axi4_stream_gen_ctrl: directed runs push expected beats
// and DONE counts; a negedge monitor pops and compares as the DUT presents them.
module tb_axi4_stream_gen_ctrl;
  localparam int LEN_W = 16;
  localparam int GAP_W = 8;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  logic             ACLK = 1'b0;
  logic             RST;
  logic             START, STOP;
  logic [LEN_W-1:0] PKT_LEN, NUM_PKTS;
  logic [GAP_W-1:0] GAP;
  logic             GEN_EN, BUSY, DONE;
  logic [LEN_W-1:0] PKT_CNT;

  axi4_stream_gen_ctrl_if axis_if ();

  axi4_stream_gen_ctrl #(.LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .ACLK     (ACLK),
    .RST      (RST),
    .START    (START),
    .STOP     (STOP),
    .PKT_LEN  (PKT_LEN),
    .NUM_PKTS (NUM_PKTS),
    .GAP      (GAP),
    .axis     (axis_if.master),
    .GEN_EN   (GEN_EN),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .PKT_CNT  (PKT_CNT)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;
  int gen_cnt = 0;
  bit exp_last_q[$];
  int exp_done_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every accepted beat pops an expected TLAST, every DONE an expected PKT_CNT.
  always @(negedge ACLK) begin
    if (!RST) begin
      if (GEN_EN === 1'b1) gen_cnt++;
      if (axis_if.TVALID && axis_if.TREADY) begin
        check("gen_en_on_beat", 32'(GEN_EN), 32'd1);
        if (exp_last_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat actual=beat required=no_beat t=%0t", $time);
        end else begin
          check("tlast_on_beat", 32'(axis_if.TLAST), 32'(exp_last_q.pop_front()));
        end
      end else begin
        check("gen_en_no_beat", 32'(GEN_EN), 32'd0);
      end
      if (!axis_if.TVALID) check("tlast_without_valid", 32'(axis_if.TLAST), 32'd0);
      if (DONE) begin
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0 t=%0t", $time);
        end else begin
          check("pkt_cnt_at_done", 32'(PKT_CNT), 32'(exp_done_q.pop_front()));
        end
      end
    end
  end

  task automatic push_pkts(input int len, input int npk);
    for (int p = 0; p < npk; p++)
      for (int b = 0; b < len; b++) exp_last_q.push_back(b == len - 1);
  endtask

  task automatic start_run(input int len, input int num, input int gap);
    PKT_LEN  = LEN_W'(len);
    NUM_PKTS = LEN_W'(num);
    GAP      = GAP_W'(gap);
    START    = 1'b1;
    @(posedge ACLK); #1;
    START = 1'b0;
  endtask

  // Drives per-cycle TREADY/START/STOP from bit vectors and records outputs per cycle.
  task automatic capture(input int n, input logic [31:0] tr, input logic [31:0] st,
                         input logic [31:0] sp, output logic [31:0] tv, output logic [31:0] tl,
                         output logic [31:0] dn, output logic [31:0] bz);
    tv = '0; tl = '0; dn = '0; bz = '0;
    for (int i = 0; i < n; i++) begin
      axis_if.TREADY = tr[i];
      START          = st[i];
      STOP           = sp[i];
      @(negedge ACLK);
      tv[i] = axis_if.TVALID;
      tl[i] = axis_if.TLAST;
      dn[i] = DONE;
      bz[i] = BUSY;
      @(posedge ACLK); #1;
    end
    START = 1'b0;
    STOP  = 1'b0;
    axis_if.TREADY = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] tv, tl, dn, bz;
    int g0;
    RST = 1'b1; START = 1'b0; STOP = 1'b0;
    PKT_LEN = '0; NUM_PKTS = '0; GAP = '0;
    axis_if.TREADY = 1'b1;
    #12;
    check("rst_tvalid",  32'(axis_if.TVALID), 32'd0);
    check("rst_tlast",   32'(axis_if.TLAST),  32'd0);
    check("rst_gen_en",  32'(GEN_EN),  32'd0);
    check("rst_busy",    32'(BUSY),    32'd0);
    check("rst_done",    32'(DONE),    32'd0);
    check("rst_pkt_cnt", 32'(PKT_CNT), 32'd0);
    @(posedge ACLK); #1; RST = 1'b0;
    @(posedge ACLK); #1;

    // Two back-to-back 4-beat packets.
    push_pkts(4, 2); exp_done_q.push_back(2); g0 = gen_cnt;
    start_run(4, 2, 0);
    capture(12, ALL, 0, 0, tv, tl, dn, bz);
    check("b2b_tvalid", tv, 32'h0FF);
    check("b2b_tlast",  tl, 32'h088);
    check("b2b_done",   dn, 32'h100);
    check("b2b_busy",   bz, 32'h0FF);
    check("b2b_gen_en_count", 32'(gen_cnt - g0), 32'd8);
    check("b2b_pkt_cnt", 32'(PKT_CNT), 32'd2);

    // Two 3-beat packets separated by a 2-cycle gap.
    push_pkts(3, 2); exp_done_q.push_back(2);
    start_run(3, 2, 2);
    capture(10, ALL, 0, 0, tv, tl, dn, bz);
    check("gap_tvalid", tv, 32'h0E7);
    check("gap_tlast",  tl, 32'h084);
    check("gap_done",   dn, 32'h100);
    check("gap_busy",   bz, 32'h0FF);
    check("gap_pkt_cnt", 32'(PKT_CNT), 32'd2);

    // Backpressure: TREADY 1,0,0,1,1,0,1 then high.
    push_pkts(4, 1); exp_done_q.push_back(1); g0 = gen_cnt;
    start_run(4, 1, 0);
    capture(9, 32'h1D9, 0, 0, tv, tl, dn, bz);
    check("stall_tvalid", tv, 32'h07F);
    check("stall_tlast",  tl, 32'h060);
    check("stall_done",   dn, 32'h080);
    check("stall_gen_en_count", 32'(gen_cnt - g0), 32'd4);
    check("stall_pkt_cnt", 32'(PKT_CNT), 32'd1);

    // Continuous mode, STOP on beat 2 of packet 3.
    push_pkts(5, 3); exp_done_q.push_back(3);
    start_run(5, 0, 0);
    capture(17, ALL, 0, 32'h800, tv, tl, dn, bz);
    check("stop_send_tvalid", tv, 32'h7FFF);
    check("stop_send_tlast",  tl, 32'h4210);
    check("stop_send_done",   dn, 32'h8000);
    check("stop_send_pkt_cnt", 32'(PKT_CNT), 32'd3);

    // STOP during the gap ends the run on the next cycle.
    push_pkts(2, 1); exp_done_q.push_back(1);
    start_run(2, 0, 3);
    capture(6, ALL, 0, 32'h8, tv, tl, dn, bz);
    check("stop_gap_tvalid", tv, 32'h03);
    check("stop_gap_busy",   bz, 32'h0F);
    check("stop_gap_done",   dn, 32'h10);
    check("stop_gap_pkt_cnt", 32'(PKT_CNT), 32'd1);

    // STOP coincident with the last-beat handshake of packet 2.
    push_pkts(2, 2); exp_done_q.push_back(2);
    start_run(2, 0, 0);
    capture(6, ALL, 0, 32'h8, tv, tl, dn, bz);
    check("stop_last_tvalid", tv, 32'h0F);
    check("stop_last_done",   dn, 32'h10);
    check("stop_last_pkt_cnt", 32'(PKT_CNT), 32'd2);

    // Reset while beat 2 of an 8-beat packet is presented.
    exp_last_q.push_back(1'b0);
    start_run(8, 0, 0);
    capture(1, ALL, 0, 0, tv, tl, dn, bz);
    RST = 1'b1; #1;
    check("midrst_tvalid",  32'(axis_if.TVALID), 32'd0);
    check("midrst_gen_en",  32'(GEN_EN),  32'd0);
    check("midrst_busy",    32'(BUSY),    32'd0);
    check("midrst_done",    32'(DONE),    32'd0);
    check("midrst_pkt_cnt", 32'(PKT_CNT), 32'd0);
    @(posedge ACLK); #1; RST = 1'b0;
    capture(3, ALL, 0, 0, tv, tl, dn, bz);
    check("postrst_idle_tvalid", tv, 32'h0);
    check("postrst_idle_busy",   bz, 32'h0);
    push_pkts(2, 1); exp_done_q.push_back(1);
    start_run(2, 1, 0);
    capture(4, ALL, 0, 0, tv, tl, dn, bz);
    check("postrst_run_tvalid", tv, 32'h3);
    check("postrst_run_done",   dn, 32'h4);
    check("postrst_run_pkt_cnt", 32'(PKT_CNT), 32'd1);

    // START with PKT_LEN=0 is ignored; PKT_CNT holds its last value.
    PKT_LEN = '0; NUM_PKTS = LEN_W'(1); GAP = '0;
    capture(3, ALL, 32'h1, 0, tv, tl, dn, bz);
    check("zero_len_tvalid", tv, 32'h0);
    check("zero_len_busy",   bz, 32'h0);
    check("zero_len_pkt_cnt_hold", 32'(PKT_CNT), 32'd1);

    // START and new config while busy have no effect on the running packet.
    push_pkts(3, 1); exp_done_q.push_back(1);
    start_run(3, 1, 0);
    PKT_LEN = LEN_W'(5); NUM_PKTS = LEN_W'(3); GAP = GAP_W'(4);
    capture(5, ALL, 32'h2, 0, tv, tl, dn, bz);
    check("busy_start_tvalid", tv, 32'h07);
    check("busy_start_tlast",  tl, 32'h04);
    check("busy_start_busy",   bz, 32'h07);
    check("busy_start_done",   dn, 32'h08);
    check("busy_start_pkt_cnt", 32'(PKT_CNT), 32'd1);

    capture(2, ALL, 0, 0, tv, tl, dn, bz);
    check("beat_queue_drained", 32'(exp_last_q.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
